nibble_load_sequencer: RTL and testbench
========================================

// Module: nibble_load_sequencer
// PURPOSE
//  Writer side of the 4-bit parallel load register interface. Serially collects DATA_W player/key
//  bits (MSB first), then drives a one-cycle load strobe with the assembled word into a downstream
//  parallel load register. Includes abort and inactivity-timeout handling. Sits between input
//  debouncing and the key/guess registers of the encryption game.
// PARAMETERS
//  DATA_W   4    width of assembled word / downstream register
//  TIMEOUT  255  max idle cycles between bit_valid strobes in COLLECT; 0 disables the timeout
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-low; forces IDLE and clears all outputs
//  start        in   1       begin a new word; sampled only in IDLE
//  bit_in       in   1       serial data bit, qualified by bit_valid
//  bit_valid    in   1       one-cycle strobe: capture bit_in
//  abort        in   1       cancel collection, no load issued
//  load         out  1       one-cycle strobe to downstream register load input
//  data_out     out  DATA_W  assembled word; drives downstream register data input
//  busy         out  1       high in COLLECT, LOAD, DONE
//  done         out  1       one-cycle pulse, cycle after load
//  timeout_err  out  1       one-cycle pulse when COLLECT is abandoned by timeout
//  bit_count    out  clog2(DATA_W+1)  bits captured so far in the current word
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE; load, done, timeout_err, busy=0; data_out=0;
//    bit_count=0; shift reg and idle counter=0.
//  - States: IDLE -> COLLECT -> LOAD -> DONE -> IDLE. All outputs are registered.
//  - IDLE: start=1 -> COLLECT; clear shift reg, bit_count, idle counter. bit_valid ignored.
//  - COLLECT: bit_valid=1 -> shreg <= {shreg[DATA_W-2:0], bit_in}; bit_count++; idle counter=0.
//    Capture of bit DATA_W (bit_count==DATA_W-1 with bit_valid) -> LOAD next cycle.
//  - LOAD: load=1 for exactly one cycle; data_out = assembled word, updated in the same cycle
//    load rises and held until the next LOAD or reset. -> DONE.
//  - DONE: done=1 for one cycle; -> IDLE. bit_count holds DATA_W until the next start.
//  - Latency: final bit_valid at edge N -> load high in cycle N+1, done in N+2.
//  - start while not IDLE: ignored. start and abort both in IDLE: abort ignored, start wins.
//  - abort in COLLECT: -> IDLE next cycle, no load, data_out unchanged. Abort beats a bit_valid in
//    the same cycle, including the final bit. abort in LOAD/DONE: ignored (load is committed).
//  - Timeout (TIMEOUT>0): in COLLECT the idle counter increments on every cycle without bit_valid.
//    When it reaches TIMEOUT -> timeout_err=1 for one cycle, -> IDLE, no load.
//    A bit_valid in the cycle the counter reaches TIMEOUT is captured and prevents the timeout.
//  - Idle counter width: clog2(TIMEOUT+1); saturates and never wraps.
//  - Mid-operation reset: aborts immediately; no load or done pulse is emitted.
// STRUCTURE
//  - Shared package (game_pkg): state encoding localparams (IDLE=2'd0, COLLECT=2'd1, LOAD=2'd2,
//    DONE=2'd3) and the default DATA_W, which is shared with the parallel load registers.
//  - One natural sub-module: idle_timeout_counter (clear, enable, TIMEOUT param, expired out).
//  - Everything else, including the FSM and the shift register, lives in this module.
// TESTING
//  1. reset=0 mid-COLLECT after 2 bits -> same cycle: load=0, busy=0, bit_count=0, state IDLE.
//  2. start, then bits 1,0,1,1 with gaps -> load=1 one cycle, data_out=4'b1011; done next cycle.
//  3. start, bits 1,1 then abort together with the 3rd bit_valid -> no load, data_out keeps its
//     previous value, busy=0.
//  4. TIMEOUT=5: start, 1 bit, then no bit_valid for 5 cycles -> timeout_err pulse, IDLE, no load.
//     A variant with bit_valid on the 5th idle cycle -> no timeout.
//  5. start asserted during COLLECT/LOAD -> ignored. Back-to-back words 4'hA then 4'h5 -> two load
//     pulses carrying A then 5.
//  6. Integrated with the downstream 4-bit load register: after word 4'h6, register holds 6 and
//     stays 6 when no further load is issued.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the encryption game datapath: sequencer state encoding and the
// word width common to the serial loader and the parallel load registers.
package game_pkg;

  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    LOAD    = 2'd2,
    DONE    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/idle_timeout_counter.sv
// Saturating idle-cycle counter; expired is combinational and flags the enabled cycle that
// brings the count to TIMEOUT. No backpressure; TIMEOUT=0 never expires.
module idle_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] idle_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (clear) begin
      idle_cnt <= '0;
    end else if (enable && idle_cnt != LIMIT) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // A cycle with clear set is not idle, so it can never be the expiring cycle.
  assign expired = (TIMEOUT > 0) && enable && !clear && (idle_cnt == LIMIT - 1'b1);

endmodule

// File: rtl/nibble_load_sequencer.sv
// Collects DATA_W serial bits MSB first and strobes them into a parallel load register; final
// bit at edge N -> load in cycle N+1, done in N+2. No backpressure: abort or timeout drops the word.
module nibble_load_sequencer
  import game_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        bit_in,
  input  logic                        bit_valid,
  input  logic                        abort,
  output logic                        load,
  output logic [DATA_W-1:0]           data_out,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout_err,
  output logic [$clog2(DATA_W+1)-1:0] bit_count
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  seq_state_t        state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic              idle_clear;
  logic              idle_en;
  logic              idle_expired;

  assign shreg_nxt  = {shreg[DATA_W-2:0], bit_in};
  assign idle_clear = (state == IDLE && start) || (state == COLLECT && bit_valid);
  assign idle_en    = (state == COLLECT) && !bit_valid;

  idle_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (idle_clear),
    .enable (idle_en),
    .expired(idle_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      load        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      data_out    <= '0;
      bit_count   <= '0;
      shreg       <= '0;
    end else begin
      load        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= COLLECT;
            busy      <= 1'b1;
            shreg     <= '0;
            bit_count <= '0;
          end
        end
        COLLECT: begin
          // Abort outranks both a bit capture and an expiring timeout in the same cycle.
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bit_valid) begin
            shreg     <= shreg_nxt;
            bit_count <= bit_count + 1'b1;
            if (bit_count == LAST_BIT) begin
              state    <= LOAD;
              load     <= 1'b1;
              data_out <= shreg_nxt;
            end
          end else if (idle_expired) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        LOAD: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_load_sequencer.sv
// Self-checking bench: table of serial words plus hand sequences for reset, start-ignore and
// the downstream load register; loaded words are scored against a queue of expected values.
module tb_nibble_load_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       bit_in;
  logic       bit_valid;
  logic       abort;
  logic       load;
  logic [3:0] data_out;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [2:0] bit_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] sb[$];
  bit         done_due = 1'b0;
  logic [3:0] ds_reg;

  typedef struct {
    logic [3:0] word;
    int         gap;
    int         abort_bit;
    logic       exp_load;
    logic       exp_tmo;
    logic [3:0] exp_data;
    logic [2:0] exp_count;
  } vec_t;

  vec_t vecs[9];

  nibble_load_sequencer #(
    .DATA_W (4),
    .TIMEOUT(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .abort      (abort),
    .load       (load),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .bit_count  (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-bit parallel load register.
  always @(posedge clk or negedge reset) begin
    if (!reset) ds_reg <= 4'h0;
    else if (load) ds_reg <= data_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every load pulse must carry the next expected word, followed by done.
  always @(negedge clk) begin
    if (done_due) begin
      check("done_after_load", 32'(done), 32'd1);
      check("load_one_cycle", 32'(load), 32'd0);
    end
    done_due = 1'b0;
    if (load) begin
      if (sb.size() == 0) begin
        check("unexpected_load", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        check("load_data", 32'(data_out), 32'(sb.pop_front()));
      end
      done_due = 1'b1;
    end
  end

  task automatic send_word(input logic [3:0] w, input int gap, input int abort_bit,
                           output logic saw_tmo);
    saw_tmo = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          if (timeout_err) saw_tmo = 1'b1;
        end
      end
      if (saw_tmo) return;
      bit_in    = w[3-i];
      bit_valid = 1'b1;
      abort     = (i == abort_bit);
      tick();
      bit_valid = 1'b0;
      abort     = 1'b0;
      if (i == abort_bit) return;
    end
  endtask

  initial begin
    logic       tmo;
    logic [3:0] w5;

    vecs[0] = '{4'hA, 0, 7, 1'b1, 1'b0, 4'hA, 3'd4};
    vecs[1] = '{4'h5, 0, 7, 1'b1, 1'b0, 4'h5, 3'd4};
    vecs[2] = '{4'hB, 2, 7, 1'b1, 1'b0, 4'hB, 3'd4};
    vecs[3] = '{4'hC, 1, 2, 1'b0, 1'b0, 4'hB, 3'd2};
    vecs[4] = '{4'hE, 0, 3, 1'b0, 1'b0, 4'hB, 3'd3};
    vecs[5] = '{4'h6, 4, 7, 1'b1, 1'b0, 4'h6, 3'd4};
    vecs[6] = '{4'h9, 5, 7, 1'b0, 1'b1, 4'h6, 3'd1};
    vecs[7] = '{4'hF, 1, 7, 1'b1, 1'b0, 4'hF, 3'd4};
    vecs[8] = '{4'h0, 3, 7, 1'b1, 1'b0, 4'h0, 3'd4};

    reset = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; abort = 1'b0;
    #1;
    check("rst_load", 32'(load), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_count", 32'(bit_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    for (int k = 0; k < 9; k++) begin
      if (vecs[k].exp_load) sb.push_back(vecs[k].exp_data);
      send_word(vecs[k].word, vecs[k].gap, vecs[k].abort_bit, tmo);
      repeat (3) tick();
      check("vec_busy", 32'(busy), 32'd0);
      check("vec_data", 32'(data_out), 32'(vecs[k].exp_data));
      check("vec_count", 32'(bit_count), 32'(vecs[k].exp_count));
      check("vec_tmo_seen", 32'(tmo), 32'(vecs[k].exp_tmo));
      check("vec_tmo_pulse", 32'(timeout_err), 32'd0);
      check("vec_sb_drained", 32'(sb.size()), 32'd0);
    end

    // start (and abort) held through COLLECT, LOAD and DONE: one clean word 4'h5.
    w5 = 4'h5;
    sb.push_back(w5);
    start = 1'b1;
    tick();
    check("hold_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bit_in    = w5[3-i];
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    abort     = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    check("hold_busy_end", 32'(busy), 32'd0);
    check("hold_count", 32'(bit_count), 32'd4);
    check("hold_data", 32'(data_out), 32'h5);
    check("hold_sb_drained", 32'(sb.size()), 32'd0);

    // Reset mid-COLLECT after two bits.
    start = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    tick();
    bit_in = 1'b0;
    tick();
    bit_valid = 1'b0;
    check("mid_count", 32'(bit_count), 32'd2);
    check("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_load", 32'(load), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_count", 32'(bit_count), 32'd0);
    check("arst_data", 32'(data_out), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    tick();
    bit_valid = 1'b0;
    tick();
    check("idle_ignores_bits", 32'(bit_count), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Downstream register keeps 6 once no further load is issued.
    sb.push_back(4'h6);
    send_word(4'h6, 1, 7, tmo);
    repeat (3) tick();
    check("ds_loaded", 32'(ds_reg), 32'h6);
    send_word(4'h3, 0, 1, tmo);
    repeat (10) tick();
    check("ds_hold", 32'(ds_reg), 32'h6);
    check("ds_data_out", 32'(data_out), 32'h6);
    check("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
